// File: rtl/urv_timer_irq.sv
// Timer-interrupt generator: compares the free-running 40-bit tick count against a
// programmable compare value and raises a level interrupt, with optional auto-reload.
module urv_timer_irq #(
    parameter int g_period_width  = 24,
    parameter int g_overrun_width = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [39:0] time_i,
    input  logic        wr_i,
    input  logic [1:0]  wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [1:0]  rd_addr_i,
    output logic [31:0] rd_data_o,
    input  logic        irq_ack_i,
    output logic        irq_o
);

    localparam logic [1:0] ADDR_CMP_LO = 2'd0;
    localparam logic [1:0] ADDR_CMP_HI = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_ARMED    = 2'd1,
        S_PENDING  = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [39:0]                  cmp_q, cmp_d;
    logic [31:0]                  shadow_q, shadow_d;
    logic [g_period_width-1:0]    period_q, period_d;
    logic                         enable_q, enable_d;
    logic                         periodic_q, periodic_d;
    logic [g_overrun_width-1:0]   overrun_q, overrun_d;
    logic [31:0]                  rd_data_q, rd_data_d;

    logic        wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_period;
    logic        disable_wr;
    logic [39:0] time_diff;
    logic        hit, hit_eff, reload_en;
    logic [39:0] cmp_reload;
    logic [31:0] ctrl_rd;

    assign wr_cmp_lo  = wr_i && (wr_addr_i == ADDR_CMP_LO);
    assign wr_cmp_hi  = wr_i && (wr_addr_i == ADDR_CMP_HI);
    assign wr_ctrl    = wr_i && (wr_addr_i == ADDR_CTRL);
    assign wr_period  = wr_i && (wr_addr_i == ADDR_PERIOD);
    assign disable_wr = wr_ctrl && !wr_data_i[0];

    // Modular difference: "at or past compare" within half the 40-bit range, so
    // both the tick count and the reloaded compare value may wrap.
    assign time_diff  = time_i - cmp_q;
    assign hit        = ~time_diff[39];
    // A compare write in the same cycle wins; the hit is re-evaluated next cycle.
    assign hit_eff    = hit && !wr_cmp_hi;
    assign reload_en  = periodic_q && (period_q != '0);
    assign cmp_reload = cmp_q + {{(40-g_period_width){1'b0}}, period_q};

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        state_d    = state_q;
        cmp_d      = cmp_q;
        shadow_d   = shadow_q;
        period_d   = period_q;
        enable_d   = enable_q;
        periodic_d = periodic_q;
        overrun_d  = overrun_q;

        if (wr_cmp_lo) shadow_d = wr_data_i;
        if (wr_period) period_d = wr_data_i[g_period_width-1:0];
        if (wr_ctrl) begin
            enable_d   = wr_data_i[0];
            periodic_d = wr_data_i[1];
        end

        if (disable_wr) begin
            state_d = S_DISARMED;
        end else begin
            unique case (state_q)
                S_DISARMED: begin
                    if (wr_ctrl && wr_data_i[0]) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (hit_eff) begin
                        state_d = S_PENDING;
                        if (reload_en) cmp_d = cmp_reload;
                    end
                end
                S_PENDING: begin
                    if (hit_eff && reload_en) begin
                        cmp_d = cmp_reload;
                        if (!irq_ack_i && (overrun_q != '1)) overrun_d = overrun_q + 1'b1;
                    end else if (irq_ack_i) begin
                        if (reload_en) begin
                            state_d = S_ARMED;
                        end else begin
                            state_d  = S_DISARMED;
                            enable_d = 1'b0;
                        end
                    end
                end
                default: state_d = S_DISARMED;
            endcase
        end

        if (wr_cmp_hi) cmp_d = {wr_data_i[7:0], shadow_q};
        if (wr_ctrl && wr_data_i[3]) overrun_d = '0;
    end

    always_comb begin
        ctrl_rd    = '0;
        ctrl_rd[0] = enable_q;
        ctrl_rd[1] = periodic_q;
        ctrl_rd[2] = (state_q == S_PENDING);
        ctrl_rd[8 +: g_overrun_width] = overrun_q;

        rd_data_d = '0;
        unique case (rd_addr_i)
            ADDR_CMP_LO: rd_data_d = cmp_q[31:0];
            ADDR_CMP_HI: rd_data_d = {24'd0, cmp_q[39:32]};
            ADDR_CTRL:   rd_data_d = ctrl_rd;
            ADDR_PERIOD: rd_data_d = {{(32-g_period_width){1'b0}}, period_q};
            default:     rd_data_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_DISARMED;
            cmp_q      <= '0;
            shadow_q   <= '0;
            period_q   <= '0;
            enable_q   <= 1'b0;
            periodic_q <= 1'b0;
            overrun_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmp_q      <= cmp_d;
            shadow_q   <= shadow_d;
            period_q   <= period_d;
            enable_q   <= enable_d;
            periodic_q <= periodic_d;
            overrun_q  <= overrun_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign irq_o     = (state_q == S_PENDING);
    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_urv_timer_irq.sv
// Directed bench for urv_timer_irq: a table of compare/time match vectors plus
// hand-written sequences for one-shot, periodic, overrun, wrap and override cases.
module tb_urv_timer_irq;

    localparam logic [1:0] A_LO = 2'd0, A_HI = 2'd1, A_CTRL = 2'd2, A_PER = 2'd3;
    localparam logic [39:0] T_MAX = 40'hFF_FFFF_FFFF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [39:0] time_i;
    logic        wr_i;
    logic [1:0]  wr_addr_i;
    logic [31:0] wr_data_i;
    logic [1:0]  rd_addr_i;
    logic [31:0] rd_data_o;
    logic        irq_ack_i;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    urv_timer_irq #(.g_period_width(24), .g_overrun_width(8)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .time_i    (time_i),
        .wr_i      (wr_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o),
        .irq_ack_i (irq_ack_i),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [39:0] cmp;
        logic [39:0] tm;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        wr_i = 1'b1; wr_addr_i = addr; wr_data_i = data;
        step();
        wr_i = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
        rd_addr_i = addr;
        step();
        check(name, 64'(rd_data_o), 64'(exp));
    endtask

    task automatic set_cmp(input logic [39:0] cmp);
        wr(A_LO, cmp[31:0]);
        wr(A_HI, {24'd0, cmp[39:32]});
    endtask

    // Ramp time_i one tick per cycle; expected irq is high after a listed fire time,
    // and stays high while unacknowledged when do_ack is clear.
    task automatic ramp(input string name, input logic [39:0] t0, input int n,
                        input logic [39:0] f0, input logic [39:0] f1, input logic [39:0] f2,
                        input bit do_ack);
        bit prev = 1'b0;
        bit exp;
        for (int i = 0; i < n; i++) begin
            time_i    = t0 + 40'(i);
            irq_ack_i = do_ack && prev;
            step();
            irq_ack_i = 1'b0;
            exp = (time_i == f0) || (time_i == f1) || (time_i == f2) || (!do_ack && prev);
            check(name, 64'(irq_o), 64'(exp));
            prev = exp;
        end
    endtask

    initial begin
        vecs[0] = '{cmp: 40'd100,          tm: 40'd99,            exp_irq: 1'b0};
        vecs[1] = '{cmp: 40'd100,          tm: 40'd100,           exp_irq: 1'b1};
        vecs[2] = '{cmp: 40'd100,          tm: 40'd101,           exp_irq: 1'b1};
        vecs[3] = '{cmp: 40'd0,            tm: 40'h7F_FFFF_FFFF,  exp_irq: 1'b1};
        vecs[4] = '{cmp: 40'd0,            tm: 40'h80_0000_0000,  exp_irq: 1'b0};
        vecs[5] = '{cmp: T_MAX - 40'd2,    tm: 40'd2,             exp_irq: 1'b1};
        vecs[6] = '{cmp: 40'd5,            tm: T_MAX,             exp_irq: 1'b0};
        vecs[7] = '{cmp: 40'h7F_FFFF_FFFF, tm: 40'h20,            exp_irq: 1'b0};

        rst_i = 1'b0; time_i = '0; wr_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        rd_addr_i = '0; irq_ack_i = 1'b0;
        #12;
        check("reset_irq", 64'(irq_o), 64'd0);
        check("reset_rd", 64'(rd_data_o), 64'd0);
        rst_i = 1'b1;
        step();
        for (int a = 0; a < 4; a++) rd_check("reset_reg", 2'(a), 32'd0);

        // Match-condition table, one-shot mode.
        for (int i = 0; i < 8; i++) begin
            wr(A_CTRL, 32'd0);
            time_i = vecs[i].tm;
            set_cmp(vecs[i].cmp);
            wr(A_CTRL, 32'd1);
            step();
            check($sformatf("match_vec%0d", i), 64'(irq_o), 64'(vecs[i].exp_irq));
        end
        wr(A_CTRL, 32'd0);

        // One-shot ramp from 90.
        time_i = 40'd90;
        set_cmp(40'd100);
        wr(A_CTRL, 32'd1);
        ramp("oneshot", 40'd90, 11, 40'd100, 40'd100, 40'd100, 1'b0);
        irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
        check("oneshot_ack_irq", 64'(irq_o), 64'd0);
        rd_check("oneshot_ctrl", A_CTRL, 32'h0);

        // Periodic with acks: fires at 50, 60, 70.
        time_i = 40'd40;
        set_cmp(40'd50);
        wr(A_PER, 32'd10);
        wr(A_CTRL, 32'd3);
        ramp("periodic", 40'd41, 35, 40'd50, 40'd60, 40'd70, 1'b1);
        rd_check("periodic_cmp", A_LO, 32'd80);
        wr(A_CTRL, 32'd0);

        // Overrun: PERIOD=5, no ack over 50..80.
        time_i = 40'd45;
        set_cmp(40'd50);
        wr(A_PER, 32'd5);
        wr(A_CTRL, 32'd3);
        ramp("overrun", 40'd46, 35, 40'd50, 40'd50, 40'd50, 1'b0);
        rd_check("overrun_ctrl", A_CTRL, 32'h0607);
        wr(A_CTRL, 32'hB);
        rd_check("overrun_clear", A_CTRL, 32'h0007);
        check("overrun_irq_held", 64'(irq_o), 64'd1);
        irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
        check("overrun_ack", 64'(irq_o), 64'd0);
        wr(A_CTRL, 32'd0);

        // Overrun saturation, then disable retains the count.
        set_cmp(40'd100);
        wr(A_PER, 32'd1);
        wr(A_CTRL, 32'd3);
        ramp("saturate", 40'd100, 321, 40'd100, 40'd100, 40'd100, 1'b0);
        rd_check("saturate_ctrl", A_CTRL, 32'hFF07);
        wr(A_CTRL, 32'd0);
        check("disable_irq", 64'(irq_o), 64'd0);
        rd_check("disable_keeps_overrun", A_CTRL, 32'hFF00);
        wr(A_CTRL, 32'h8);
        rd_check("overrun_clear_disabled", A_CTRL, 32'h0);

        // Wrap: compare at 2^40-3, reload to 7.
        time_i = T_MAX - 40'd9;
        set_cmp(T_MAX - 40'd2);
        wr(A_PER, 32'd10);
        wr(A_CTRL, 32'd3);
        ramp("wrap", T_MAX - 40'd8, 20, T_MAX - 40'd2, 40'd7, 40'd7, 1'b1);
        rd_check("wrap_cmp_lo", A_LO, 32'd17);
        rd_check("wrap_cmp_hi", A_HI, 32'd0);
        wr(A_CTRL, 32'd0);

        // Atomic compare update.
        time_i = 40'h20;
        set_cmp(40'h7F_FFFF_FFFF);
        wr(A_CTRL, 32'd1);
        step();
        check("atomic_armed_noirq", 64'(irq_o), 64'd0);
        wr(A_LO, 32'h10);
        check("atomic_lo_noirq", 64'(irq_o), 64'd0);
        rd_check("atomic_lo_not_applied", A_LO, 32'hFFFF_FFFF);
        wr(A_HI, 32'd0);
        check("atomic_hi_write_cycle", 64'(irq_o), 64'd0);
        step();
        check("atomic_hi_fire", 64'(irq_o), 64'd1);
        irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
        check("atomic_ack", 64'(irq_o), 64'd0);

        // CMP_HI write wins over a simultaneous hit in ARMED.
        wr(A_LO, 32'h1000);
        wr(A_CTRL, 32'd1);
        wr(A_HI, 32'd0);
        check("hiwr_wins_irq", 64'(irq_o), 64'd0);
        step();
        check("hiwr_reeval_irq", 64'(irq_o), 64'd0);
        rd_check("hiwr_cmp", A_LO, 32'h1000);

        // Ack coincident with a periodic hit: hit wins, no overrun.
        wr(A_CTRL, 32'd0);
        time_i = 40'h1000;
        wr(A_PER, 32'h10);
        wr(A_CTRL, 32'd3);
        step();
        check("ackhit_fire", 64'(irq_o), 64'd1);
        time_i = 40'h1010;
        irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
        check("ackhit_irq_held", 64'(irq_o), 64'd1);
        rd_check("ackhit_ctrl", A_CTRL, 32'h0007);
        rd_check("ackhit_cmp", A_LO, 32'h1020);

        // Ack outside PENDING is ignored.
        irq_ack_i = 1'b1; step();
        check("ack_to_armed", 64'(irq_o), 64'd0);
        step(); irq_ack_i = 1'b0;
        check("ack_armed_ignored", 64'(irq_o), 64'd0);
        time_i = 40'h1020;
        step();
        check("armed_after_ack_fires", 64'(irq_o), 64'd1);

        // Disable during PENDING.
        wr(A_CTRL, 32'd0);
        check("disable_pending_irq", 64'(irq_o), 64'd0);

        // Async reset mid-PENDING.
        time_i = 40'h1030;
        wr(A_CTRL, 32'd1);
        step();
        check("prereset_fire", 64'(irq_o), 64'd1);
        rst_i = 1'b0;
        #1;
        check("async_reset_irq", 64'(irq_o), 64'd0);
        check("async_reset_rd", 64'(rd_data_o), 64'd0);
        #3;
        rst_i = 1'b1;
        rd_check("post_reset_lo", A_LO, 32'd0);
        rd_check("post_reset_ctrl", A_CTRL, 32'd0);
        rd_check("post_reset_period", A_PER, 32'd0);
        check("post_reset_irq", 64'(irq_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
